// File: rtl/reshaper_mem_responder.sv
// reshaper_mem_responder
// Memory-side responder for the reshaper address interface. Reads have a fixed
// latency of MEM_DELAY cycles and writes take one cycle, both against a
// DEPTH x DW array. It also keeps saturating request counters and a sticky
// range-error flag. The array has no reset, so it maps onto an SRAM macro.
module reshaper_mem_responder #(
    parameter int AW        = 16,
    parameter int DW        = 512,
    parameter int DEPTH     = 4096,
    parameter int MEM_DELAY = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init_pulse,
    input  logic [AW-1:0] raddr,
    input  logic          raddr_vld,
    output logic [DW-1:0] rdata,
    output logic          rdata_vld,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          wdata_vld,
    output logic [AW-1:0] rd_cnt,
    output logic [AW-1:0] wr_cnt,
    output logic          addr_err
);

    // Array index width; an address is range-checked before its low bits index the array
    localparam int            IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] CNT_MAX   = {AW{1'b1}};
    localparam logic [AW-1:0] CNT_ONE   = AW'(1'b1);

    // Saturating increment for the request counters
    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] cnt, input logic inc);
        logic [AW-1:0] res;
        if (inc && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    logic [DW-1:0] mem_r [DEPTH];

    logic          rd_ok_s;
    logic          wr_ok_s;
    logic          rd_bad_s;
    logic          wr_bad_s;
    logic [DW-1:0] rd_word_s;

    logic          pipe_vld_r  [MEM_DELAY];
    logic [DW-1:0] pipe_data_r [MEM_DELAY];

    logic [AW-1:0] rd_cnt_r;
    logic [AW-1:0] wr_cnt_r;
    logic          addr_err_r;

    // Classify requests and pick the read word (write-first on same-address collision)
    always_comb begin
        rd_ok_s   = raddr_vld && ({1'b0, raddr} < DEPTH_LIM);
        wr_ok_s   = wdata_vld && ({1'b0, waddr} < DEPTH_LIM);
        rd_bad_s  = raddr_vld && !rd_ok_s;
        wr_bad_s  = wdata_vld && !wr_ok_s;
        rd_word_s = '0;
        if (!rd_ok_s) begin
            rd_word_s = '0;
        end else if (wr_ok_s && (waddr == raddr)) begin
            rd_word_s = wdata;
        end else begin
            rd_word_s = mem_r[raddr[IW-1:0]];
        end
    end

    // Array write port; out-of-range writes are dropped and contents survive reset
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[waddr[IW-1:0]] <= wdata;
        end
    end

    // Read pipeline: MEM_DELAY stages of {vld, data}; data is zeroed wherever vld is low,
    // so the last stage drives the outputs directly and reads as 0 when idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < MEM_DELAY; k++) begin
                pipe_vld_r[k]  <= 1'b0;
                pipe_data_r[k] <= '0;
            end
        end else begin
            pipe_vld_r[0]  <= raddr_vld;
            pipe_data_r[0] <= raddr_vld ? rd_word_s : '0;
            for (int k = 1; k < MEM_DELAY; k++) begin
                pipe_vld_r[k]  <= pipe_vld_r[k-1];
                pipe_data_r[k] <= pipe_vld_r[k-1] ? pipe_data_r[k-1] : '0;
            end
        end
    end

    // Request counters and sticky range error; init_pulse restarts them but still
    // accounts for a request arriving in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_cnt_r   <= '0;
            wr_cnt_r   <= '0;
            addr_err_r <= 1'b0;
        end else if (init_pulse) begin
            rd_cnt_r   <= raddr_vld ? CNT_ONE : '0;
            wr_cnt_r   <= wdata_vld ? CNT_ONE : '0;
            addr_err_r <= rd_bad_s || wr_bad_s;
        end else begin
            rd_cnt_r   <= sat_inc(rd_cnt_r, raddr_vld);
            wr_cnt_r   <= sat_inc(wr_cnt_r, wdata_vld);
            addr_err_r <= addr_err_r || rd_bad_s || wr_bad_s;
        end
    end

    assign rdata     = pipe_data_r[MEM_DELAY-1];
    assign rdata_vld = pipe_vld_r[MEM_DELAY-1];
    assign rd_cnt    = rd_cnt_r;
    assign wr_cnt    = wr_cnt_r;
    assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_reshaper_mem_responder.sv
// Directed testbench for reshaper_mem_responder: a full-size instance for the
// functional scenarios and a 4-bit-address instance for counter saturation.
module tb_reshaper_mem_responder;

    localparam int AW    = 16;
    localparam int DW    = 512;
    localparam int DEPTH = 4096;
    localparam int MD    = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          init_pulse = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic          raddr_vld = 1'b0;
    logic [DW-1:0] rdata;
    logic          rdata_vld;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic          wdata_vld = 1'b0;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] wr_cnt;
    logic          addr_err;

    logic          s_init_pulse = 1'b0;
    logic [3:0]    s_raddr = 4'd0;
    logic          s_raddr_vld = 1'b0;
    logic [7:0]    s_rdata;
    logic          s_rdata_vld;
    logic [3:0]    s_waddr = 4'd0;
    logic [7:0]    s_wdata = 8'd0;
    logic          s_wdata_vld = 1'b0;
    logic [3:0]    s_rd_cnt;
    logic [3:0]    s_wr_cnt;
    logic          s_addr_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] val_a;
    logic [DW-1:0] val_b;
    logic [DW-1:0] val_c;
    logic [DW-1:0] val_d;

    always #5 clk = ~clk;

    reshaper_mem_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MEM_DELAY(MD)) dut (
        .clk(clk), .reset_n(reset_n), .init_pulse(init_pulse),
        .raddr(raddr), .raddr_vld(raddr_vld), .rdata(rdata), .rdata_vld(rdata_vld),
        .waddr(waddr), .wdata(wdata), .wdata_vld(wdata_vld),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .addr_err(addr_err)
    );

    reshaper_mem_responder #(.AW(4), .DW(8), .DEPTH(16), .MEM_DELAY(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .init_pulse(s_init_pulse),
        .raddr(s_raddr), .raddr_vld(s_raddr_vld), .rdata(s_rdata), .rdata_vld(s_rdata_vld),
        .waddr(s_waddr), .wdata(s_wdata), .wdata_vld(s_wdata_vld),
        .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt), .addr_err(s_addr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if (rdata_vld !== 1'b0 || rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got vld=%0b data=%0h, expected vld=0 data=0", rdata_vld, rdata);
        end
        n_tests++;
        if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rd=%0d wr=%0d err=%0b, expected 0 0 0", rd_cnt, wr_cnt, addr_err);
        end
        reset_n = 1'b1;
        tick();
        for (int a = 1; a <= 3; a++) begin
            raddr     = 16'(a);
            raddr_vld = 1'b1;
            tick();
        end
        raddr_vld = 1'b0;
        reset_n   = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int j = 0; j < MD + 4; j++) begin
            n_tests++;
            if (rdata_vld !== 1'b0 || rdata !== '0) begin
                n_fail++;
                $display("FAIL reset_drop cyc%0d: got vld=%0b data=%0h, expected vld=0 data=0", j, rdata_vld, rdata);
            end
            tick();
        end
        n_tests++;
        if (rd_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_rd_cnt: got %0d, expected 0", rd_cnt);
        end
    endtask

    task automatic test_write_read();
        waddr     = 16'd5;
        wdata     = val_a;
        wdata_vld = 1'b1;
        tick();
        wdata_vld = 1'b0;
        raddr     = 16'd5;
        raddr_vld = 1'b1;
        tick();
        raddr_vld = 1'b0;
        for (int j = 0; j < MD - 1; j++) begin
            n_tests++;
            if (rdata_vld !== 1'b0 || rdata !== '0) begin
                n_fail++;
                $display("FAIL wr_rd_early cyc%0d: got vld=%0b data=%0h, expected vld=0 data=0", j, rdata_vld, rdata);
            end
            tick();
        end
        n_tests++;
        if (rdata_vld !== 1'b1 || rdata !== val_a) begin
            n_fail++;
            $display("FAIL wr_rd_resp: got vld=%0b data=%0h, expected vld=1 data=%0h", rdata_vld, rdata, val_a);
        end
        tick();
        n_tests++;
        if (rdata_vld !== 1'b0 || rdata !== '0) begin
            n_fail++;
            $display("FAIL wr_rd_after: got vld=%0b data=%0h, expected vld=0 data=0", rdata_vld, rdata);
        end
    endtask

    task automatic test_collision();
        waddr     = 16'd7;
        wdata     = val_b;
        wdata_vld = 1'b1;
        tick();
        raddr     = 16'd7;
        raddr_vld = 1'b1;
        wdata     = val_c;
        tick();
        raddr_vld = 1'b0;
        wdata_vld = 1'b0;
        for (int j = 0; j < MD - 1; j++) tick();
        n_tests++;
        if (rdata_vld !== 1'b1 || rdata !== val_c) begin
            n_fail++;
            $display("FAIL coll_wfirst: got vld=%0b data=%0h, expected vld=1 data=%0h", rdata_vld, rdata, val_c);
        end
        raddr_vld = 1'b1;
        tick();
        raddr_vld = 1'b0;
        waddr     = 16'd7;
        wdata     = val_d;
        wdata_vld = 1'b1;
        tick();
        wdata_vld = 1'b0;
        for (int j = 1; j < MD - 1; j++) tick();
        n_tests++;
        if (rdata_vld !== 1'b1 || rdata !== val_c) begin
            n_fail++;
            $display("FAIL coll_inflight: got vld=%0b data=%0h, expected vld=1 data=%0h", rdata_vld, rdata, val_c);
        end
        raddr_vld = 1'b1;
        tick();
        raddr_vld = 1'b0;
        for (int j = 0; j < MD - 1; j++) tick();
        n_tests++;
        if (rdata_vld !== 1'b1 || rdata !== val_d) begin
            n_fail++;
            $display("FAIL coll_later: got vld=%0b data=%0h, expected vld=1 data=%0h", rdata_vld, rdata, val_d);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int r;
        init_pulse = 1'b1;
        tick();
        init_pulse = 1'b0;
        for (int i = 0; i < 64; i++) begin
            waddr     = 16'(i);
            wdata     = DW'(i);
            wdata_vld = 1'b1;
            tick();
        end
        wdata_vld = 1'b0;
        for (int k = 0; k < 64 + MD; k++) begin
            if (k < 64) begin
                raddr     = 16'(k);
                raddr_vld = 1'b1;
            end else begin
                raddr_vld = 1'b0;
            end
            tick();
            r = k - (MD - 1);
            n_tests++;
            if (r >= 0 && r < 64) begin
                if (rdata_vld !== 1'b1 || rdata !== DW'(r)) begin
                    n_fail++;
                    $display("FAIL stream cyc%0d: got vld=%0b data=%0h, expected vld=1 data=%0h", k, rdata_vld, rdata, r);
                end
            end else begin
                if (rdata_vld !== 1'b0 || rdata !== '0) begin
                    n_fail++;
                    $display("FAIL stream_idle cyc%0d: got vld=%0b data=%0h, expected vld=0 data=0", k, rdata_vld, rdata);
                end
            end
        end
        n_tests++;
        if (rd_cnt !== 16'd64 || wr_cnt !== 16'd64) begin
            n_fail++;
            $display("FAIL stream_cnt: got rd=%0d wr=%0d, expected 64 64", rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_range();
        raddr     = 16'd4096;
        raddr_vld = 1'b1;
        tick();
        raddr_vld = 1'b0;
        n_tests++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_err: got %0b, expected 1", addr_err);
        end
        for (int j = 0; j < MD - 1; j++) tick();
        n_tests++;
        if (rdata_vld !== 1'b1 || rdata !== '0) begin
            n_fail++;
            $display("FAIL range_rd: got vld=%0b data=%0h, expected vld=1 data=0", rdata_vld, rdata);
        end
        waddr     = 16'd4097;
        wdata     = val_a;
        wdata_vld = 1'b1;
        tick();
        wdata_vld = 1'b0;
        raddr     = 16'd1;
        raddr_vld = 1'b1;
        tick();
        raddr_vld = 1'b0;
        for (int j = 0; j < MD - 1; j++) tick();
        n_tests++;
        if (rdata_vld !== 1'b1 || rdata !== DW'(1)) begin
            n_fail++;
            $display("FAIL range_wr_ignored: got vld=%0b data=%0h, expected vld=1 data=1", rdata_vld, rdata);
        end
        n_tests++;
        if (rd_cnt !== 16'd66 || wr_cnt !== 16'd65 || addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_cnt: got rd=%0d wr=%0d err=%0b, expected 66 65 1", rd_cnt, wr_cnt, addr_err);
        end
        init_pulse = 1'b1;
        tick();
        init_pulse = 1'b0;
        n_tests++;
        if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL init_clear: got rd=%0d wr=%0d err=%0b, expected 0 0 0", rd_cnt, wr_cnt, addr_err);
        end
        raddr     = 16'd3;
        raddr_vld = 1'b1;
        tick();
        raddr_vld  = 1'b0;
        init_pulse = 1'b1;
        tick();
        init_pulse = 1'b0;
        for (int j = 1; j < MD - 1; j++) tick();
        n_tests++;
        if (rdata_vld !== 1'b1 || rdata !== DW'(3)) begin
            n_fail++;
            $display("FAIL init_keeps_inflight: got vld=%0b data=%0h, expected vld=1 data=3", rdata_vld, rdata);
        end
        init_pulse = 1'b1;
        raddr      = 16'd2;
        raddr_vld  = 1'b1;
        waddr      = 16'd4097;
        wdata_vld  = 1'b1;
        tick();
        init_pulse = 1'b0;
        raddr_vld  = 1'b0;
        wdata_vld  = 1'b0;
        n_tests++;
        if (rd_cnt !== 16'd1 || wr_cnt !== 16'd1 || addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL init_with_req: got rd=%0d wr=%0d err=%0b, expected 1 1 1", rd_cnt, wr_cnt, addr_err);
        end
        for (int j = 0; j < MD + 1; j++) tick();
    endtask

    task automatic test_saturation();
        s_init_pulse = 1'b1;
        tick();
        s_init_pulse = 1'b0;
        s_raddr      = 4'd0;
        s_waddr      = 4'd0;
        s_wdata      = 8'h3C;
        for (int i = 1; i <= 20; i++) begin
            s_raddr_vld = 1'b1;
            s_wdata_vld = 1'b1;
            tick();
            if (i == 14) begin
                n_tests++;
                if (s_rd_cnt !== 4'd14) begin
                    n_fail++;
                    $display("FAIL sat_mid: got %0d, expected 14", s_rd_cnt);
                end
            end
        end
        s_raddr_vld = 1'b0;
        s_wdata_vld = 1'b0;
        n_tests++;
        if (s_rd_cnt !== 4'd15 || s_wr_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_end: got rd=%0d wr=%0d, expected 15 15", s_rd_cnt, s_wr_cnt);
        end
        tick();
    endtask

    initial begin
        val_a = {16{32'hA5A5_0001}};
        val_b = {16{32'hB0B0_0002}};
        val_c = {16{32'hC3C3_0003}};
        val_d = {16{32'hD4D4_0004}};
        test_reset();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_range();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
